aes128_enc_iter: RTL
====================

Name: aes128_enc_iter

Overview:
- Iterative AES-128 encryption engine with valid/ready handshakes on input and output.
- Plaintext and key are runtime inputs, not constants.
- Computes ROUNDS_PER_CYCLE rounds per clock, with on-the-fly key expansion.
- Reuses the team's sub_byte, shift_rows and mix_columns datapath blocks. Sits between a block source (DMA/CPU FIFO) and a ciphertext sink.

Parameters:
- ROUNDS_PER_CYCLE, 1, number of AES rounds unrolled per clock. Legal values: 1, 2, 5, 10. Any other value is an elaboration error.
- CLEAR_ON_POP, 1, when 1 data_out is zeroed on the cycle after an output handshake; when 0 data_out holds the last ciphertext.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  engine can accept a block
- data_in  input  128  plaintext, byte 0 in bits [127:120]
- key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext available
- out_ready  input  1  sink accepts ciphertext
- data_out  output  128  ciphertext
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, round counter=0, internal state/round-key registers=0.
- Reset mid-operation aborts the current block immediately. No output is produced for it.
- FSM: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge:
    - state_reg <= data_in ^ key (round 0 AddRoundKey)
    - rk_reg <= key
    - rcon <= 8'h01
    - rnd <= 0
    - go to RUN
  - data_in and key are sampled only at that edge; later changes are ignored.
- RUN:
  - in_ready=0.
  - Each cycle applies ROUNDS_PER_CYCLE rounds to state_reg. Each round:
    - derive the next round key from the current round key and rcon
    - SubBytes, ShiftRows, MixColumns (omitted when rnd+i==9, the final round), AddRoundKey
  - rcon update: xtime, i.e. rcon<<1, XOR 8'h1b if bit7 was set (01,02,…,80,1b,36).
  - rnd advances by ROUNDS_PER_CYCLE.
  - When rnd reaches 10 after the update: data_out <= result, out_valid <= 1, go to DONE.
  - RUN lasts exactly 10/ROUNDS_PER_CYCLE cycles.
- Latency: input handshake at edge k gives out_valid=1 after edge k+10/ROUNDS_PER_CYCLE. That is 10 cycles for ROUNDS_PER_CYCLE=1 and 1 cycle for ROUNDS_PER_CYCLE=10.
- DONE:
  - out_valid=1; data_out stable until handshake.
  - in_ready=0. No new block is accepted while the result is pending.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE, data_out <= 0 if CLEAR_ON_POP.
- Back-to-back throughput: one block per 10/ROUNDS_PER_CYCLE + 2 cycles (accept, run, pop).
- out_ready held low indefinitely: engine stalls in DONE, no data loss, in_ready stays 0.
- in_valid asserted while busy: ignored, no side effects.
- out_ready asserted while out_valid=0: ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: AES_ABORT_EN.
- Defined:
  - adds input port abort (1 bit, synchronous, active-high).
  - abort=1 at a clock edge in RUN or DONE forces IDLE, clears out_valid, rnd and the state register, and zeroes data_out.
  - abort in IDLE has no effect. abort takes priority over the output handshake in the same cycle.
- Undefined: the port does not exist; a block, once accepted, always completes.

Test Plan:
- FIPS-197 App.B, ROUNDS_PER_CYCLE=1: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_valid exactly 10 cycles after accept, data_out 3925841d02dc09fbdc118597196a0b32, one-cycle pulse, in_ready=1 the following cycle.
- FIPS-197 App.C.1, each ROUNDS_PER_CYCLE in {1,2,5,10}: key 000102030405060708090a0b0c0d0e0f, data_in 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a with latency 10, 5, 2, 1 respectively.
- Backpressure: out_ready=0 for 20 cycles after completion; toggle data_in/key and pulse in_valid meanwhile -> data_out holds the correct ciphertext, in_ready=0 throughout, no second block is accepted, single handshake on release.
- Back-to-back: two blocks (App.B then App.C.1) with in_valid held high and out_ready=1 -> both ciphertexts correct, in order, second accepted on the cycle after the first pop.
- Async reset: assert rst_n=0 mid-RUN (after round 4) between clock edges -> out_valid=0, in_ready=1, busy=0, data_out=0 immediately. The next App.B block after reset release produces the correct result.
- AES_ABORT_EN: abort pulse in round 6 -> IDLE on the next edge, no out_valid. Abort coincident with the DONE handshake -> out_valid=0, data_out=0. A following block completes correctly.

Source files
------------

// File: rtl/aes128_enc_iter.sv
// rtl/aes128_enc_iter.sv - iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock; `define AES_ABORT_EN adds an abort input
module aes128_enc_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit CLEAR_ON_POP     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int k = 0; k < 7; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4*c+r is row r of column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, data_out_q, data_out_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic [127:0] st_v, rk_v;
  logic [7:0]   rc_v;
  logic [3:0]   rnd_next;

  // Unrolled round datapath: key expansion runs alongside each round; the last round skips MixColumns.
  always_comb begin
    st_v = st_q;
    rk_v = rk_q;
    rc_v = rcon_q;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      rk_v = next_key(rk_v, rc_v);
      rc_v = xtime(rc_v);
      if (int'(rnd_q) + i == 9) st_v = shift_rows(sub_bytes(st_v)) ^ rk_v;
      else                      st_v = mix_columns(shift_rows(sub_bytes(st_v))) ^ rk_v;
    end
    rnd_next = rnd_q + 4'(ROUNDS_PER_CYCLE);
  end

  // Next-state logic for the IDLE/RUN/DONE controller and its registered outputs.
  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rcon_d      = rcon_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d   = data_in ^ key;
          rk_d   = key;
          rcon_d = 8'h01;
          rnd_d  = 4'd0;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        st_d   = st_v;
        rk_d   = rk_v;
        rcon_d = rc_v;
        rnd_d  = rnd_next;
        if (rnd_next == 4'd10) begin
          data_out_d  = st_v;
          out_valid_d = 1'b1;
          fsm_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
          if (CLEAR_ON_POP) data_out_d = '0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
`ifdef AES_ABORT_EN
    if (abort && fsm_q != S_IDLE) begin
      fsm_d       = S_IDLE;
      out_valid_d = 1'b0;
      rnd_d       = 4'd0;
      st_d        = '0;
      data_out_d  = '0;
    end
`endif
    in_ready_d = (fsm_d == S_IDLE);
    busy_d     = (fsm_d != S_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      rcon_q      <= 8'h00;
      rnd_q       <= 4'd0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      rcon_q      <= rcon_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;

endmodule
